// File: rtl/pcie_rx_pkg.sv
// Shared types for the PCIe TRN receive path: the beat entry and the framing states.
package pcie_rx_pkg;

    localparam int RX_BEAT_W = 82;

    typedef struct packed {
        logic [63:0] rd;
        logic [7:0]  rrem_n;
        logic        rsof_n;
        logic        reof_n;
        logic        rerrfwd_n;
        logic [6:0]  rbar_hit_n;
    } rx_beat_t;

    typedef enum logic {
        IDLE,
        IN_PKT
    } rx_frm_state_t;

endpackage

// File: rtl/pcie_rx_fifo.sv
// Generic synchronous show-ahead FIFO with occupancy count.
// Latency: a written entry is at the head on the next cycle (no bypass).
// Backpressure: writer must respect count; a write while full trips an assertion.
module pcie_rx_fifo #(
    parameter int W     = 82,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          pcie_clk,
    input  logic          rst_n,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    output logic          rd_vld,
    input  logic          rd_rdy,
    output logic [W-1:0]  rd_dat,
    output logic [AW:0]   count
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] last_dat;
    logic         rd_en;
    logic         full;

    assign rd_vld = (count != '0);
    assign full   = count[AW];
    assign rd_en  = rd_vld & rd_rdy;

    // While empty, hold the last popped head so the outputs stay defined.
    assign rd_dat = rd_vld ? mem[rd_ptr[AW-1:0]] : last_dat;

    always_ff @(posedge pcie_clk) begin
        if (wr_vld) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
        end
    end

    always_ff @(posedge pcie_clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_dat <= '0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr   <= rd_ptr + 1'b1;
                last_dat <= mem[rd_ptr[AW-1:0]];
            end
            count <= count + (AW+1)'(wr_vld) - (AW+1)'(rd_en);
        end
    end

    a_no_overflow: assert property (@(posedge pcie_clk) disable iff (!rst_n) !(wr_vld && full));

endmodule

// File: rtl/pcie_rx_ingress.sv
// Elastic TRN RX ingress: framing check, orphan drop, show-ahead FIFO, TLP/error stats.
// Latency: beat accepted at cycle t is presented on rx_* at t+1.
// Backpressure: trn_rdst_rdy_n is a flop driven from registered occupancy, one beat of slack.
module pcie_rx_ingress
    import pcie_rx_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         pcie_clk,
    input  logic         rst_n,
    input  logic [63:0]  trn_rd,
    input  logic [7:0]   trn_rrem_n,
    input  logic         trn_rsof_n,
    input  logic         trn_reof_n,
    input  logic         trn_rsrc_rdy_n,
    input  logic         trn_rerrfwd_n,
    input  logic [6:0]   trn_rbar_hit_n,
    output logic         trn_rdst_rdy_n,
    output logic [63:0]  rx_rd,
    output logic [7:0]   rx_rrem_n,
    output logic         rx_rsof_n,
    output logic         rx_reof_n,
    output logic         rx_rerrfwd_n,
    output logic [6:0]   rx_rbar_hit_n,
    output logic         rx_rsrc_rdy_n,
    input  logic         rx_rdst_rdy_n,
    output logic         framing_err,
    output logic [31:0]  stat_tlp_cnt,
    output logic [31:0]  stat_frame_err_cnt,
    output logic [AW:0]  fifo_level
);

    localparam logic [AW:0] RDY_THR = (AW+1)'(DEPTH - 1);

    rx_frm_state_t state_q;
    rx_frm_state_t state_nxt;
    rx_beat_t      beat_in_dat;
    rx_beat_t      head_dat;
    logic          beat_acc;
    logic          beat_wr_vld;
    logic          head_vld;
    logic          tlp_done;
    logic          frm_err;
    logic          sof;
    logic          eof;

    assign beat_acc = ~trn_rsrc_rdy_n & ~trn_rdst_rdy_n;
    assign sof      = ~trn_rsof_n;
    assign eof      = ~trn_reof_n;

    assign beat_in_dat = '{rd:         trn_rd,
                           rrem_n:     trn_rrem_n,
                           rsof_n:     trn_rsof_n,
                           reof_n:     trn_reof_n,
                           rerrfwd_n:  trn_rerrfwd_n,
                           rbar_hit_n: trn_rbar_hit_n};

    always_comb begin
        state_nxt   = state_q;
        beat_wr_vld = 1'b0;
        tlp_done    = 1'b0;
        frm_err     = 1'b0;
        if (beat_acc) begin
            case (state_q)
                IDLE: begin
                    if (sof) begin
                        beat_wr_vld = 1'b1;
                        if (eof) begin
                            tlp_done = 1'b1;
                        end else begin
                            state_nxt = IN_PKT;
                        end
                    end else begin
                        frm_err = 1'b1;
                    end
                end
                IN_PKT: begin
                    // A stray SOF is flagged but still kept: it opens the next TLP.
                    beat_wr_vld = 1'b1;
                    frm_err     = sof;
                    if (eof) begin
                        tlp_done  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge pcie_clk) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            trn_rdst_rdy_n     <= 1'b1;
            framing_err        <= 1'b0;
            stat_tlp_cnt       <= '0;
            stat_frame_err_cnt <= '0;
        end else begin
            state_q        <= state_nxt;
            // Registered level lags one beat; the slot left at DEPTH-1 absorbs that beat.
            trn_rdst_rdy_n <= (fifo_level >= RDY_THR);
            framing_err    <= frm_err;
            if (tlp_done) begin
                stat_tlp_cnt <= stat_tlp_cnt + 32'd1;
            end
            if (frm_err) begin
                stat_frame_err_cnt <= stat_frame_err_cnt + 32'd1;
            end
        end
    end

    pcie_rx_fifo #(
        .W     (RX_BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .pcie_clk (pcie_clk),
        .rst_n    (rst_n),
        .wr_vld   (beat_wr_vld),
        .wr_dat   (beat_in_dat),
        .rd_vld   (head_vld),
        .rd_rdy   (~rx_rdst_rdy_n),
        .rd_dat   (head_dat),
        .count    (fifo_level)
    );

    assign rx_rsrc_rdy_n = ~head_vld;
    assign rx_rd         = head_dat.rd;
    assign rx_rrem_n     = head_dat.rrem_n;
    assign rx_rsof_n     = head_dat.rsof_n;
    assign rx_reof_n     = head_dat.reof_n;
    assign rx_rerrfwd_n  = head_dat.rerrfwd_n;
    assign rx_rbar_hit_n = head_dat.rbar_hit_n;

endmodule
